// File: rtl/mul_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: a shift-add sequencer driving one 16-bit Adder.
// Returns a 32-bit product with {Z, V} status and a one-cycle done pulse.

module Adder (
    input  logic [15:0] in1_i,
    input  logic [15:0] in2_i,
    output logic [15:0] out_o,
    output logic        carry_o,
    output logic [1:0]  flags_o
);
    logic [16:0] full;

    assign full    = {1'b0, in1_i} + {1'b0, in2_i};
    assign out_o   = full[15:0];
    assign carry_o = full[16];
    // {Z, C} of the 16-bit sum
    assign flags_o = {(full[15:0] == 16'h0), full[16]};
endmodule

module mul_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [1:0]  flags
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [15:0] mcand_q;
    logic [15:0] hi_q;
    logic [15:0] lo_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] product_q;
    logic [1:0]  flags_q;

    logic [15:0] sum;
    logic        carry;
    logic [1:0]  adder_flags_unused;
    logic [31:0] acc_d;

    Adder u_adder (
        .in1_i   (hi_q),
        .in2_i   (mcand_q),
        .out_o   (sum),
        .carry_o (carry),
        .flags_o (adder_flags_unused)
    );

    // Low multiplier bit selects add-and-shift or plain shift; carry becomes bit 31.
    always_comb begin
        acc_d = {1'b0, hi_q, lo_q[15:1]};
        if (lo_q[0]) begin
            acc_d = {carry, sum, lo_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= 16'h0;
            hi_q      <= 16'h0;
            lo_q      <= 16'h0;
            cnt_q     <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 32'h0;
            flags_q   <= 2'b10;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q <= a;
                        hi_q    <= 16'h0;
                        lo_q    <= b;
                        cnt_q   <= 4'h0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    hi_q  <= acc_d[31:16];
                    lo_q  <= acc_d[15:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        product_q <= acc_d;
                        flags_q   <= {(acc_d == 32'h0), (acc_d[31:16] != 16'h0)};
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign flags   = flags_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized and directed bench for mul_seq_ctrl against a plain a*b reference model.

module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [1:0]  flags;

    int vectors = 0;
    int miscompares = 0;

    mul_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    function automatic logic [1:0] ref_flags(input logic [31:0] p);
        return {(p == 32'h0), (p[31:16] != 16'h0)};
    endfunction

    // Drives one multiply from IDLE and observes it until busy drops again.
    // lat counts cycles from the accepting edge to the done cycle (cycle after E0 is 1).
    task automatic do_mul(input logic [15:0] av, input logic [15:0] bv,
                          output logic [31:0] prod, output logic [1:0] flg,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output bit early, output bit timeout);
        logic [31:0] prev;
        bit seen;
        a = av;
        b = bv;
        start = 1'b1;
        prev = product;
        tick();
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 0;
        busy_cnt = 0;
        done_cnt = 0;
        early = 1'b0;
        timeout = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (j > 0) tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (!seen) lat = j + 1;
                seen = 1'b1;
            end
            if (!seen && product !== prev) early = 1'b1;
            if (seen && !busy) begin
                timeout = 1'b0;
                break;
            end
        end
        prod = product;
        flg = flags;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        vectors++;
        if (product !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_product: got %h expected 0", product);
        end
        vectors++;
        if (flags !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 10", flags);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [4] = '{16'd3, 16'hFFFF, 16'h1234, 16'h0000};
        logic [15:0] tb [4] = '{16'd5, 16'hFFFF, 16'h0000, 16'hFFFF};
        logic [31:0] prod;
        logic [1:0]  flg;
        int lat, bc, dc;
        bit early, to;
        for (int i = 0; i < 4; i++) begin
            do_mul(ta[i], tb[i], prod, flg, lat, bc, dc, early, to);
            vectors++;
            if (to) begin
                miscompares++;
                $display("FAIL directed_timeout[%0d]: got no completion expected done", i);
            end
            vectors++;
            if (prod !== ref_prod(ta[i], tb[i])) begin
                miscompares++;
                $display("FAIL directed_product[%0d]: got %h expected %h", i, prod,
                         ref_prod(ta[i], tb[i]));
            end
            vectors++;
            if (flg !== ref_flags(ref_prod(ta[i], tb[i]))) begin
                miscompares++;
                $display("FAIL directed_flags[%0d]: got %b expected %b", i, flg,
                         ref_flags(ref_prod(ta[i], tb[i])));
            end
            vectors++;
            if (lat !== 17) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d expected 17", i, lat);
            end
            vectors++;
            if (bc !== 17) begin
                miscompares++;
                $display("FAIL directed_busy_cycles[%0d]: got %0d expected 17", i, bc);
            end
            vectors++;
            if (dc !== 1) begin
                miscompares++;
                $display("FAIL directed_done_count[%0d]: got %0d expected 1", i, dc);
            end
            vectors++;
            if (early !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_product_early[%0d]: got change expected hold", i);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dc = 0;
        bit busy_after = 1'b1;
        bit busy_later = 1'b1;
        a = 16'd7;
        b = 16'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) tick();
            start = (j == 4 || j == 16);
            a = start ? 16'd2 : 16'($urandom);
            b = start ? 16'd2 : 16'($urandom);
            if (done) dc++;
            if (j == 17) busy_after = busy;
            if (j == 19) busy_later = busy;
        end
        start = 1'b0;
        vectors++;
        if (product !== 32'd63) begin
            miscompares++;
            $display("FAIL ignore_product: got %h expected %h", product, 32'd63);
        end
        vectors++;
        if (dc !== 1) begin
            miscompares++;
            $display("FAIL ignore_done_count: got %0d expected 1", dc);
        end
        vectors++;
        if (busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_busy_after_done: got %b expected 0", busy_after);
        end
        vectors++;
        if (busy_later !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_no_restart: got %b expected 0", busy_later);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] prod;
        logic [1:0]  flg;
        int lat, bc, dc;
        bit early, to;
        int late_done = 0;
        do_mul(16'd100, 16'd200, prod, flg, lat, bc, dc, early, to);
        vectors++;
        if (prod !== 32'd20000) begin
            miscompares++;
            $display("FAIL midrst_first_product: got %h expected %h", prod, 32'd20000);
        end
        a = 16'd3;
        b = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 7; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy, done, product, flags} !== {1'b0, 1'b0, 32'h0, 2'b10}) begin
            miscompares++;
            $display("FAIL midrst_outputs: got busy=%b done=%b product=%h flags=%b expected 0 0 0 10",
                     busy, done, product, flags);
        end
        for (int j = 0; j < 20; j++) begin
            tick();
            if (done) late_done++;
        end
        vectors++;
        if (late_done !== 0) begin
            miscompares++;
            $display("FAIL midrst_no_done: got %0d pulses expected 0", late_done);
        end
        // Reset and start together: start must not be accepted.
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_start_same_cycle: got busy=%b expected 0", busy);
        end
        do_mul(16'd4, 16'd4, prod, flg, lat, bc, dc, early, to);
        vectors++;
        if (prod !== 32'd16 || to) begin
            miscompares++;
            $display("FAIL midrst_followup_product: got %h expected %h", prod, 32'd16);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ca;
        logic [15:0] cb;
        logic [31:0] exp_p;
        int cyc = 0;
        int last_done = -1;
        int waited;
        ca = 16'($urandom);
        cb = 16'($urandom);
        a = ca;
        b = cb;
        start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            waited = 0;
            do begin
                tick();
                cyc++;
                waited++;
            end while (!done && waited < 40);
            exp_p = ref_prod(ca, cb);
            vectors++;
            if (!done) begin
                miscompares++;
                $display("FAIL b2b_timeout[%0d]: got no done expected done", n);
                break;
            end
            vectors++;
            if (product !== exp_p || flags !== ref_flags(exp_p)) begin
                miscompares++;
                $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b (a=%h b=%h)",
                         n, product, flags, exp_p, ref_flags(exp_p), ca, cb);
            end
            if (last_done >= 0) begin
                vectors++;
                if (cyc - last_done !== 18) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected 18", n, cyc - last_done);
                end
            end
            last_done = cyc;
            ca = (n % 50 == 7) ? 16'hFFFF : 16'($urandom);
            cb = (n % 50 == 9) ? 16'h0000 : 16'($urandom);
            a = ca;
            b = cb;
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
